pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Fetch sequencer and next-PC controller for the single-cycle MIPS core. It owns the update of the `program_counter` register: each cycle it decides whether the PC holds, advances by 4, or is redirected to a branch/jump target or exception vector. It runs a request/ready fetch handshake with instruction memory, so wait states and decode stalls freeze the PC cleanly. It sits between `program_counter`, instruction memory, the branch/jump unit and the hazard/stall source.

## Interface
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset
- EXC_VECTOR, 32'h0000_0080, exception handler address (used only with PC_SEQ_EXC_EN)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- pc  in  32  current PC, from `program_counter` outPC
- pc_next  out  32  next PC, to `program_counter` inpPC
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address; always equals pc
- imem_ready  in  1  fetch data valid this cycle
- imem_rdata  in  32  fetched instruction
- instr_valid  out  1  instr is valid for decode
- instr  out  32  registered instruction
- stall  in  1  decode cannot accept; hold instruction and PC
- redirect_valid  in  1  taken branch/jump for the current instruction
- redirect_target  in  32  branch/jump target
- exc_req  in  1  exception raised by the current instruction
- eret  in  1  current instruction is ERET
- epc  out  32  saved exception PC

## Operation
- States:
  - BOOT: pc_next = RESET_VECTOR; imem_req = 0; always goes to FETCH next cycle.
  - FETCH: imem_req = 1.
    - imem_ready = 0: pc_next = pc (wait state).
    - imem_ready = 1: instr <= imem_rdata and instr_valid <= 1; go to HOLD.
  - HOLD: imem_req = 0; instr_valid = 1.
    - stall = 1: pc_next = pc.
    - stall = 0: the instruction retires; pc_next = retire target; instr_valid <= 0; go to FETCH.
- Retire target priority, sampled only at retirement:
  1. exc_req → EXC_VECTOR
  2. eret → epc
  3. redirect_valid → redirect_target
  4. otherwise pc + 4
- Arithmetic:
  - pc + 4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
  - Redirect targets with bits[1:0] ≠ 0: see Configuration.
- redirect_valid, exc_req and eret are ignored outside HOLD, and ignored in HOLD while stall = 1.
- In every non-retire cycle pc_next = pc (BOOT excepted).
- Reset values:
  - state = BOOT
  - imem_req = 0, instr_valid = 0
  - instr = 32'h0, epc = 32'h0
  - pc_next = RESET_VECTOR
- Reset mid-operation: all state clears asynchronously, any fetch in flight is abandoned, and imem_req drops in the same cycle.

## Timing
- Zero-wait memory (imem_ready high in the first FETCH cycle): 2 cycles per instruction (FETCH, HOLD).
- Each memory wait state adds 1 cycle; each stall cycle adds 1 cycle.
- The PC changes exactly once per retired instruction, on the clock edge ending the retire cycle.
- imem_addr is stable for the whole of FETCH.
- instr_valid rises on the edge that captures imem_rdata and falls on the edge after retirement.
- Redirect and exception are seen at the next fetch with no extra bubble: the first FETCH after retirement uses the new PC.
- Simultaneous stall = 1 and redirect_valid = 1: the redirect is not taken until stall = 0; it must still be asserted in that cycle.

## Configuration
- Macro: PC_SEQ_EXC_EN.
- Defined:
  - exc_req and eret are honoured.
  - On an exception retire, epc <= pc.
  - A misaligned redirect target (bits[1:0] ≠ 0) is itself treated as an exception: EXC_VECTOR is taken and epc <= pc.
- Undefined:
  - exc_req and eret are ignored.
  - epc is constant 0.
  - Misaligned targets are forced aligned: pc_next = {redirect_target[31:2], 2'b00}.

## Test plan
- Reset with RESET_VECTOR = 32'h100, zero-wait memory, no stalls → imem_addr sequence 0x100, 0x104, 0x108, one fetch per 2 cycles; instr_valid toggles 0/1.
- Hold imem_ready low for 3 cycles at PC 0x104 → imem_req and imem_addr = 0x104 stay stable for 4 cycles; pc_next = pc throughout.
- Assert stall for 5 cycles in HOLD together with redirect_valid, target 0x400 → instr unchanged and PC frozen; after stall falls with redirect still high, next fetch is at 0x400.
- PC = 32'hFFFF_FFFC retires with no redirect → next fetch at 0x0.
- With PC_SEQ_EXC_EN: exc_req at PC 0x20 → fetch at 0x80 and epc = 0x20; a later eret → fetch at 0x20. Redirect to 0x402 → fetch at 0x80. Without the macro, redirect to 0x402 → fetch at 0x400.
- Assert rst while in FETCH → imem_req drops immediately; after release, BOOT for one cycle, then fetch at RESET_VECTOR.

Source files
------------

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch sequencer and next-PC controller (optional exceptions via PC_SEQ_EXC_EN)
module pc_sequencer #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc,
   output logic [31:0] pc_next,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] instr,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   input  logic        exc_req,
   input  logic        eret,
   output logic [31:0] epc
);

   localparam logic [1:0] ST_BOOT  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [31:0] instr_q, instr_d;
   logic        instr_valid_q, instr_valid_d;
   logic        retire;
   logic        take_exc;
   logic        take_eret;
   logic [31:0] retire_target;

   // The only cycle that may move the PC is the un-stalled HOLD cycle.
   assign retire = (state_q == ST_HOLD) && !stall;

`ifdef PC_SEQ_EXC_EN
   logic [31:0] epc_q;
   logic        misaligned;

   // A misaligned redirect is promoted to an exception, below exc_req and eret in priority.
   assign misaligned = redirect_valid && (redirect_target[1:0] != 2'b00);
   assign take_exc   = exc_req || (!eret && misaligned);
   assign take_eret  = !exc_req && eret;

   // Capture the faulting PC when an exception retires.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         epc_q <= 32'h0;
      end else if (retire && take_exc) begin
         epc_q <= pc;
      end
   end

   assign epc = epc_q;
`else
   logic unused_in;

   // Exception inputs and the low target bits have no effect in this build.
   assign unused_in = ^{exc_req, eret, redirect_target[1:0]};
   assign take_exc  = 1'b0;
   assign take_eret = 1'b0;
   assign epc       = 32'h0;
`endif

   // Retire target priority: exception, eret, redirect (word aligned), sequential.
   always_comb begin
      retire_target = pc + 32'd4;
      if (take_exc) begin
         retire_target = EXC_VECTOR;
      end else if (take_eret) begin
         retire_target = epc;
      end else if (redirect_valid) begin
         retire_target = {redirect_target[31:2], 2'b00};
      end
   end

   // FSM next state, instruction capture and next-PC selection.
   always_comb begin
      state_d       = state_q;
      instr_d       = instr_q;
      instr_valid_d = instr_valid_q;
      pc_next       = pc;
      imem_req      = 1'b0;
      case (state_q)
         ST_BOOT: begin
            pc_next = RESET_VECTOR;
            state_d = ST_FETCH;
         end
         ST_FETCH: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               instr_d       = imem_rdata;
               instr_valid_d = 1'b1;
               state_d       = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (!stall) begin
               pc_next       = retire_target;
               instr_valid_d = 1'b0;
               state_d       = ST_FETCH;
            end
         end
         default: begin
            pc_next       = RESET_VECTOR;
            instr_valid_d = 1'b0;
            state_d       = ST_BOOT;
         end
      endcase
   end

   // State registers; reset abandons any fetch in flight immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_BOOT;
         instr_q       <= 32'h0;
         instr_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         instr_q       <= instr_d;
         instr_valid_q <= instr_valid_d;
      end
   end

   assign imem_addr   = pc;
   assign instr       = instr_q;
   assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer
module tb_pc_sequencer;

   localparam logic [31:0] RV = 32'h0000_0100;
   localparam logic [31:0] EV = 32'h0000_0080;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] pc = 32'h0;
   logic [31:0] pc_next;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        instr_valid;
   logic [31:0] instr;
   logic        stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_target = 32'h0;
   logic        exc_req = 1'b0;
   logic        eret = 1'b0;
   logic [31:0] epc;

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] sb_q[$];
   logic        req_seen = 1'b0;

   typedef struct {
      int          wait_n;
      int          stall_n;
      logic        rv;
      logic [31:0] tgt;
      logic        exc;
      logic        er;
      logic [31:0] rdata;
      logic [31:0] exp_next;
      logic [31:0] exp_epc;
   } vec_t;

   vec_t vecs[10];

   pc_sequencer #(.RESET_VECTOR(RV), .EXC_VECTOR(EV)) dut (
      .clk(clk), .rst(rst), .pc(pc), .pc_next(pc_next),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr(instr),
      .stall(stall), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .exc_req(exc_req), .eret(eret), .epc(epc)
   );

   always #5 clk = ~clk;

   // program_counter register model
   always @(posedge clk) pc <= pc_next;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Scoreboard: every new fetch must be at the next expected address.
   always @(negedge clk) begin
      if (imem_req === 1'b1 && !req_seen) begin
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_underflow: unexpected fetch at %h", imem_addr);
         end else begin
            check("fetch_addr", imem_addr, sb_q.pop_front());
         end
      end
      req_seen <= (imem_req === 1'b1);
   end

   function automatic vec_t mk(input int w, input int s, input logic rv, input logic [31:0] t,
                               input logic ex, input logic er, input logic [31:0] d,
                               input logic [31:0] nx, input logic [31:0] ep);
      vec_t v;
      v.wait_n = w; v.stall_n = s; v.rv = rv; v.tgt = t; v.exc = ex; v.er = er;
      v.rdata = d; v.exp_next = nx; v.exp_epc = ep;
      return v;
   endfunction

   task automatic run_vec(input vec_t v);
      int          budget = 0;
      logic [31:0] fa;
      while (imem_req !== 1'b1 && budget < 10) begin
         @(negedge clk);
         budget++;
      end
      if (imem_req !== 1'b1) begin
         n_cmp++;
         n_bad++;
         $display("FAIL fetch_timeout: imem_req %b expected 1", imem_req);
         return;
      end
      fa = imem_addr;
      check("addr_is_pc", imem_addr, pc);
      for (int i = 0; i < v.wait_n; i++) begin
         imem_ready = 1'b0;
         #1;
         check("wait_pc_hold", pc_next, pc);
         check("wait_addr", imem_addr, fa);
         check("wait_req", {31'h0, imem_req}, 32'h1);
         @(negedge clk);
      end
      imem_ready = 1'b1;
      imem_rdata = v.rdata;
      #1;
      check("fetch_pc_hold", pc_next, pc);
      @(negedge clk);
      imem_ready = 1'b0;
      imem_rdata = $urandom;
      check("hold_valid", {31'h0, instr_valid}, 32'h1);
      check("instr", instr, v.rdata);
      check("hold_req", {31'h0, imem_req}, 32'h0);
      for (int i = 0; i < v.stall_n; i++) begin
         stall = 1'b1;
         redirect_valid = v.rv;
         redirect_target = v.tgt;
         exc_req = 1'b1;
         eret = 1'b1;
         #1;
         check("stall_pc_hold", pc_next, pc);
         @(negedge clk);
         check("stall_instr", instr, v.rdata);
      end
      stall = 1'b0;
      redirect_valid = v.rv;
      redirect_target = v.tgt;
      exc_req = v.exc;
      eret = v.er;
      #1;
      check("retire_next", pc_next, v.exp_next);
      sb_q.push_back(v.exp_next);
      @(negedge clk);
      redirect_valid = 1'b0;
      exc_req = 1'b0;
      eret = 1'b0;
      check("valid_fall", {31'h0, instr_valid}, 32'h0);
      check("epc", epc, v.exp_epc);
   endtask

   initial begin
`ifdef PC_SEQ_EXC_EN
      vecs[6] = mk(0, 0, 1'b0, 32'h0,   1'b1, 1'b0, 32'hA000_0006, EV,           32'h20);
      vecs[7] = mk(0, 0, 1'b0, 32'h0,   1'b0, 1'b1, 32'hA000_0007, 32'h20,       32'h20);
      vecs[8] = mk(0, 1, 1'b1, 32'h402, 1'b0, 1'b0, 32'hA000_0008, EV,           32'h20);
      vecs[9] = mk(0, 0, 1'b0, 32'h0,   1'b0, 1'b0, 32'hA000_0009, 32'h84,       32'h20);
`else
      vecs[6] = mk(0, 0, 1'b0, 32'h0,   1'b1, 1'b0, 32'hA000_0006, 32'h24,       32'h0);
      vecs[7] = mk(0, 0, 1'b0, 32'h0,   1'b0, 1'b1, 32'hA000_0007, 32'h28,       32'h0);
      vecs[8] = mk(0, 1, 1'b1, 32'h402, 1'b0, 1'b0, 32'hA000_0008, 32'h400,      32'h0);
      vecs[9] = mk(0, 0, 1'b0, 32'h0,   1'b0, 1'b0, 32'hA000_0009, 32'h404,      32'h0);
`endif
      vecs[0] = mk(0, 0, 1'b0, 32'h0,         1'b0, 1'b0, 32'hA000_0000, 32'h104,       32'h0);
      vecs[1] = mk(3, 0, 1'b0, 32'h0,         1'b0, 1'b0, 32'hA000_0001, 32'h108,       32'h0);
      vecs[2] = mk(0, 5, 1'b1, 32'h400,       1'b0, 1'b0, 32'hA000_0002, 32'h400,       32'h0);
      vecs[3] = mk(0, 0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'hA000_0003, 32'hFFFF_FFFC, 32'h0);
      vecs[4] = mk(0, 0, 1'b0, 32'h0,         1'b0, 1'b0, 32'hA000_0004, 32'h0,         32'h0);
      vecs[5] = mk(1, 2, 1'b1, 32'h20,        1'b0, 1'b0, 32'hA000_0005, 32'h20,        32'h0);

      @(negedge clk);
      @(negedge clk);
      check("rst_req", {31'h0, imem_req}, 32'h0);
      check("rst_valid", {31'h0, instr_valid}, 32'h0);
      check("rst_instr", instr, 32'h0);
      check("rst_epc", epc, 32'h0);
      check("rst_pc_next", pc_next, RV);
      @(posedge clk);
      #1;
      sb_q.push_back(RV);
      rst = 1'b0;
      @(negedge clk);
      check("boot_req", {31'h0, imem_req}, 32'h0);
      check("boot_pc_next", pc_next, RV);
      @(negedge clk);

      for (int i = 0; i < 10; i++) run_vec(vecs[i]);

      // reset while a fetch is pending
      #2;
      check("pre_rst_req", {31'h0, imem_req}, 32'h1);
      rst = 1'b1;
      #1;
      check("async_rst_req", {31'h0, imem_req}, 32'h0);
      check("async_rst_pc_next", pc_next, RV);
      check("async_rst_epc", epc, 32'h0);
      @(negedge clk);
      @(posedge clk);
      #1;
      sb_q.push_back(RV);
      rst = 1'b0;
      @(negedge clk);
      check("reboot_req", {31'h0, imem_req}, 32'h0);
      @(negedge clk);
      run_vec(mk(0, 0, 1'b0, 32'h0, 1'b0, 1'b0, 32'hB000_0000, 32'h104, 32'h0));
      @(negedge clk);
      check("sb_drained", sb_q.size(), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
